// File: rtl/nibble_serial_alu_ctrl.sv
// Runs word-wide AND/OR/ADD/SUB through an external 4-bit ALU slice.
// The slice is used one nibble per clock, LSB first, with the carry registered between nibbles.
module nibble_serial_alu_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [2:0]             op,
   input  logic [4*NIBBLES-1:0]   a,
   input  logic [4*NIBBLES-1:0]   b,
   input  logic                   cin,
   input  logic                   abort,
   output logic                   ready,
   output logic                   done,
   output logic                   err,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   cout,
   output logic                   zero,
   output logic                   ovf,
   output logic [3:0]             alu_a,
   output logic [3:0]             alu_b,
   output logic                   alu_cin,
   output logic [2:0]             alu_control,
   input  logic [3:0]             alu_result,
   input  logic                   alu_cout
);
   localparam int W  = 4*NIBBLES;
   localparam int IW = $clog2(NIBBLES);
   localparam logic [2:0] OP_AND = 3'd0, OP_OR = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd6;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;

   logic [W-1:0]  a_q, b_q, res_sh, res_full;
   logic [2:0]    op_q;
   logic          carry_q, err_q;
   logic [IW-1:0] idx_q;
   logic          legal, last, is_logic, accept, step;

   assign legal    = op inside {OP_AND, OP_OR, OP_ADD, OP_SUB};
   assign last     = (idx_q == IW'(NIBBLES-1));
   assign is_logic = ~op_q[1];
   assign accept   = (state_q == IDLE) && start && legal;
   assign step     = (state_q == RUN) && !abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start && legal) state_d = RUN;
         RUN:     if (abort) state_d = IDLE;
                  else if (last) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready       = (state_q == IDLE);
      done        = (state_q == DONE);
      err         = err_q;
      alu_control = op_q;
      alu_a       = 4'd0;
      alu_b       = 4'd0;
      alu_cin     = 1'b0;
      if (state_q == RUN) begin
         alu_a   = a_q[4*idx_q +: 4];
         alu_b   = b_q[4*idx_q +: 4];
         alu_cin = carry_q;
      end
   end

   // Word as it will look once the current nibble's slice output is folded in.
   always_comb begin
      res_full = res_sh;
      res_full[4*idx_q +: 4] = alu_result;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0; b_q <= '0; op_q <= 3'd0; carry_q <= 1'b0; idx_q <= '0;
         res_sh <= '0; result <= '0; cout <= 1'b0; zero <= 1'b0; ovf <= 1'b0;
         err_q <= 1'b0;
      end else begin
         err_q <= (state_q == IDLE) && start && !legal;
         if (accept) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            carry_q <= (op == OP_ADD) ? cin : (op == OP_SUB);
            idx_q   <= '0;
         end else if (step) begin
            res_sh  <= res_full;
            carry_q <= is_logic ? 1'b0 : alu_cout;
            idx_q   <= IW'(idx_q + 1'b1);
            if (last) begin
               result <= res_full;
               cout   <= is_logic ? 1'b0 : alu_cout;
               zero   <= (res_full == '0);
               case (op_q)
                  OP_ADD:  ovf <= (a_q[W-1] == b_q[W-1]) && (res_full[W-1] != a_q[W-1]);
                  OP_SUB:  ovf <= (a_q[W-1] != b_q[W-1]) && (res_full[W-1] != a_q[W-1]);
                  default: ovf <= 1'b0;
               endcase
            end
         end
      end
   end
endmodule

// File: tb/tb_nibble_serial_alu_ctrl.sv
// Bench for nibble_serial_alu_ctrl: a behavioural 4-bit slice plus a word-level reference model.
module tb_nibble_serial_alu_ctrl;
   localparam int N = 4;
   localparam int W = 4*N;

   logic clk = 1'b0, rst_n = 1'b0;
   logic start = 1'b0, cin = 1'b0, abort = 1'b0;
   logic [2:0] op = 3'd0;
   logic [W-1:0] a = '0, b = '0;
   logic ready, done, err, cout, zero, ovf, alu_cin, alu_cout;
   logic [W-1:0] result;
   logic [3:0] alu_a, alu_b, alu_result;
   logic [2:0] alu_control;
   logic [4:0] s;

   int checks = 0, errors = 0;
   logic [W-1:0] exp_res = '0;
   logic exp_co = 1'b0, exp_z = 1'b0, exp_ov = 1'b0;

   nibble_serial_alu_ctrl #(.NIBBLES(N)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b), .cin(cin),
      .abort(abort), .ready(ready), .done(done), .err(err), .result(result),
      .cout(cout), .zero(zero), .ovf(ovf), .alu_a(alu_a), .alu_b(alu_b),
      .alu_cin(alu_cin), .alu_control(alu_control), .alu_result(alu_result),
      .alu_cout(alu_cout));

   always #5 clk = ~clk;

   // External 4-bit ALU slice.
   always_comb begin
      case (alu_control)
         3'd0:    s = {1'b0, alu_a & alu_b};
         3'd1:    s = {1'b0, alu_a | alu_b};
         3'd2:    s = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_cin};
         3'd6:    s = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_cin};
         default: s = 5'd0;
      endcase
   end
   assign alu_result = s[3:0];
   assign alu_cout   = s[4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic void model(input logic [2:0] o, input logic [W-1:0] x, y, input logic c,
                                 output logic [W-1:0] r, output logic co, output logic ov);
      longint sx, sy, sum;
      logic [W:0] full;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      co = 1'b0; ov = 1'b0; full = '0;
      case (o)
         3'd0: r = x & y;
         3'd1: r = x | y;
         3'd2: begin
            full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
            sum = sx + sy + longint'(c);
            r = full[W-1:0]; co = full[W];
            ov = (sum > 32767) || (sum < -32768);
         end
         default: begin
            full = {1'b0, x} + {1'b0, ~y} + {{W{1'b0}}, 1'b1};
            sum = sx - sy;
            r = full[W-1:0]; co = full[W];
            ov = (sum > 32767) || (sum < -32768);
         end
      endcase
   endfunction

   // Carry arriving at nibble i, from whole-word arithmetic on the low 4*i bits.
   function automatic logic carry_in(input logic [2:0] o, input logic [W-1:0] x, y,
                                     input logic c, input int i);
      longint mask, sum;
      logic [W-1:0] yy;
      if (o == 3'd0 || o == 3'd1) return 1'b0;
      yy   = (o == 3'd6) ? ~y : y;
      mask = (longint'(1) << (4*i)) - 1;
      sum  = (longint'(x) & mask) + (longint'(yy) & mask) + ((o == 3'd6) ? 1 : longint'(c));
      return logic'((sum >> (4*i)) & 1);
   endfunction

   function automatic logic [3:0] nib(input logic [W-1:0] v, input int i);
      return v[4*i +: 4];
   endfunction

   task automatic chk_out(input string tag);
      chk({tag, ".result"}, 32'(result), 32'(exp_res));
      chk({tag, ".cout"},   32'(cout),   32'(exp_co));
      chk({tag, ".zero"},   32'(zero),   32'(exp_z));
      chk({tag, ".ovf"},    32'(ovf),    32'(exp_ov));
   endtask

   // mode: 0 complete, 1 abort at RUN cycle cut, 2 reset at RUN cycle cut
   task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x, y,
                         input logic c, input int mode, input int cut);
      logic [W-1:0] r; logic co, ov;
      model(o, x, y, c, r, co, ov);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y; cin = c;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
         op = 3'd2; start = (i != N-1);
         chk({tag, ".ready_run"}, 32'(ready), 32'd0);
         chk({tag, ".done_run"},  32'(done),  32'd0);
         chk({tag, ".alu_a"},     32'(alu_a), 32'(nib(x, i)));
         chk({tag, ".alu_b"},     32'(alu_b), 32'(nib(y, i)));
         chk({tag, ".alu_cin"},   32'(alu_cin), 32'(carry_in(o, x, y, c, i)));
         chk({tag, ".alu_ctl"},   32'(alu_control), 32'(o));
         chk({tag, ".held"},      32'(result), 32'(exp_res));
         if (mode != 0 && i == cut) begin
            start = 1'b0;
            if (mode == 1) begin
               abort = 1'b1;
               @(negedge clk);
               abort = 1'b0;
               chk({tag, ".ab_ready"}, 32'(ready), 32'd1);
               chk({tag, ".ab_done"},  32'(done),  32'd0);
               chk_out({tag, ".ab"});
            end else begin
               rst_n = 1'b0;
               #1;
               exp_res = '0; exp_co = 1'b0; exp_z = 1'b0; exp_ov = 1'b0;
               chk({tag, ".rs_ready"}, 32'(ready), 32'd1);
               chk({tag, ".rs_done"},  32'(done),  32'd0);
               chk({tag, ".rs_err"},   32'(err),   32'd0);
               chk({tag, ".rs_alu"},   32'({alu_a, alu_b, alu_cin, alu_control}), 32'd0);
               chk_out({tag, ".rs"});
               @(negedge clk);
               rst_n = 1'b1;
               @(negedge clk);
               chk({tag, ".rs_ready2"}, 32'(ready), 32'd1);
               chk({tag, ".rs_done2"},  32'(done),  32'd0);
            end
            @(negedge clk);
            chk({tag, ".no_done"}, 32'(done), 32'd0);
            return;
         end
         @(negedge clk);
      end
      exp_res = r; exp_co = co; exp_z = (r == '0); exp_ov = ov;
      chk({tag, ".done"},  32'(done),  32'd1);
      chk({tag, ".ready_done"}, 32'(ready), 32'd0);
      chk({tag, ".alu_cin_done"}, 32'(alu_cin), 32'd0);
      chk_out(tag);
      @(negedge clk);
      chk({tag, ".ready_after"}, 32'(ready), 32'd1);
      chk({tag, ".done_after"},  32'(done),  32'd0);
   endtask

   task automatic err_op(input logic [2:0] o);
      @(negedge clk);
      start = 1'b1; op = o; a = W'($urandom); b = W'($urandom);
      @(negedge clk);
      start = 1'b0;
      chk("err.pulse", 32'(err), 32'd1);
      chk("err.ready", 32'(ready), 32'd1);
      chk_out("err.hold");
      @(negedge clk);
      chk("err.clear", 32'(err), 32'd0);
      chk("err.ready2", 32'(ready), 32'd1);
   endtask

   initial begin
      logic [2:0] ops [4] = '{3'd0, 3'd1, 3'd2, 3'd6};
      #12;
      chk("rst.ready", 32'(ready), 32'd1);
      chk("rst.done",  32'(done),  32'd0);
      chk("rst.err",   32'(err),   32'd0);
      chk("rst.alu",   32'({alu_a, alu_b, alu_cin, alu_control}), 32'd0);
      chk_out("rst");
      rst_n = 1'b1;

      run_op("add_ff_1",   3'd2, 16'h00FF, 16'h0001, 1'b0, 0, 0);
      run_op("add_ffff_1", 3'd2, 16'hFFFF, 16'h0001, 1'b0, 0, 0);
      run_op("add_7fff_1", 3'd2, 16'h7FFF, 16'h0001, 1'b0, 0, 0);
      run_op("add_cin",    3'd2, 16'h0FFF, 16'h0000, 1'b1, 0, 0);
      run_op("sub_8000_1", 3'd6, 16'h8000, 16'h0001, 1'b0, 0, 0);
      run_op("sub_3_5",    3'd6, 16'h0003, 16'h0005, 1'b1, 0, 0);
      run_op("and",        3'd0, 16'hF0F0, 16'h3C3C, 1'b1, 0, 0);
      err_op(3'd3);
      run_op("or",         3'd1, 16'hF0F0, 16'h3C3C, 1'b1, 0, 0);
      err_op(3'd7);
      run_op("abort_i2",   3'd2, 16'hAAAA, 16'h5555, 1'b1, 1, 2);
      run_op("abort_last", 3'd6, 16'h1234, 16'h4321, 1'b0, 1, N-1);
      run_op("add_after_ab", 3'd2, 16'h1234, 16'h1111, 1'b0, 0, 0);
      run_op("reset_i2",   3'd2, 16'hAAAA, 16'h5555, 1'b0, 2, 2);
      run_op("add_after_rs", 3'd2, 16'h1234, 16'h1111, 1'b0, 0, 0);

      for (int k = 0; k < 24; k++)
         run_op("rand", ops[$urandom_range(0, 3)], W'($urandom), W'($urandom), 1'($urandom), 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
